sar_search: RTL

SAR_SEARCH -- requirements
Module: sar_search

---
 rtl/sar_search_pkg.sv | 21 ++
 rtl/sar_search_if.sv | 42 ++++
 rtl/sar_search.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller:
// FSM state encoding, default operand width and the steps-counter width rule.
package sar_search_pkg;

  // Default operand width of the comparator being driven.
  localparam int SAR_WIDTH_DEFAULT = 4;

  // Controller states. DONE always lasts exactly one cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } sar_state_e;

  // A binary search over 2^w values needs at most w+1 comparisons.
  // The counter must hold that count, so it gets clog2(w+2) bits.
  function automatic int sar_steps_width(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/sar_search_if.sv
// Bus between the search controller and its environment (requester plus
// external magnitude comparator).
//
// Handshake: start is a request level with an implicit ready of !busy; it is
// accepted on a rising edge only while the controller is in IDLE or DONE and
// is ignored while busy=1. Completion is the single-cycle done pulse; found,
// result, steps and error are valid from that cycle until the next accepted
// start. agb/alb/aeb must be combinational from guess (no latency).
//
// master: the controller side. slave: the requester/comparator side.
interface sar_search_if
  import sar_search_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEFAULT
);

  localparam int STEPS_W = sar_steps_width(WIDTH);

  logic               start;
  logic               agb;
  logic               alb;
  logic               aeb;
  logic [WIDTH-1:0]   guess;
  logic               busy;
  logic               done;
  logic               found;
  logic [WIDTH-1:0]   result;
  logic [STEPS_W-1:0] steps;
  logic               error;
  sar_state_e         state;   // debug view of the controller FSM

  modport master (
    input  start, agb, alb, aeb,
    output guess, busy, done, found, result, steps, error, state
  );

  modport slave (
    output start, agb, alb, aeb,
    input  guess, busy, done, found, result, steps, error, state
  );

endinterface

// File: rtl/sar_search.sv
// Successive-approximation (binary) search controller. Drives a probe value
// onto the b side of an external comparator and narrows a [lo, hi] interval
// from the agb/alb/aeb flags, one comparison per clock.
//
// Optional feature macro: SAR_SEARCH_FLAG_CHECK_EN
//   defined   : comparator flags that are not exactly one-hot end the search
//               with error=1, found=0 and a done pulse.
//   undefined : flags decode with priority aeb > agb > alb, all-zero counts
//               as alb, and error is tied low.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,   // asynchronous, active low
  sar_search_if.master  bus
);

  localparam int STEPS_W = sar_steps_width(WIDTH);

  // lo/hi carry one extra bit so guess+1 at all-ones cannot wrap to zero.
  localparam logic [WIDTH:0]       HI_INIT  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]       BOUND_1  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [STEPS_W-1:0]   STEP_1   = {{(STEPS_W-1){1'b0}}, 1'b1};

  sar_state_e         state, state_n;
  logic [WIDTH:0]     lo, lo_n;
  logic [WIDTH:0]     hi, hi_n;
  logic [WIDTH-1:0]   guess, guess_n;
  logic [WIDTH-1:0]   result, result_n;
  logic [STEPS_W-1:0] steps, steps_n;
  logic               found, found_n;

  // Decoded comparator outcome for the current guess.
  logic hit;       // target == guess
  logic go_up;     // target >  guess
  logic go_down;   // target <  guess
  logic bad_flags; // flag combination rejected

`ifdef SAR_SEARCH_FLAG_CHECK_EN
  logic err, err_n;

  // Strict decode: anything other than exactly one flag is an error.
  always_comb begin
    bad_flags = !$onehot({bus.aeb, bus.agb, bus.alb});
    hit       = bus.aeb & ~bad_flags;
    go_up     = bus.agb & ~bad_flags;
    go_down   = bus.alb & ~bad_flags;
  end
`else
  // Priority decode: aeb wins, then agb; everything else moves hi down.
  always_comb begin
    bad_flags = 1'b0;
    hit       = bus.aeb;
    go_up     = ~bus.aeb & bus.agb;
    go_down   = ~bus.aeb & ~bus.agb;
  end
`endif

  // Next-state and datapath: start handling, one comparison per SEARCH cycle.
  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    guess_n  = guess;
    result_n = result;
    steps_n  = steps;
    found_n  = found;
`ifdef SAR_SEARCH_FLAG_CHECK_EN
    err_n    = err;
`endif
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n  = SEARCH;
          lo_n     = '0;
          hi_n     = HI_INIT;
          guess_n  = WIDTH'(HI_INIT >> 1);
          steps_n  = '0;
          found_n  = 1'b0;
          result_n = '0;
`ifdef SAR_SEARCH_FLAG_CHECK_EN
          err_n    = 1'b0;
`endif
        end else if (state == DONE) begin
          // Results stay registered; only the state falls back.
          state_n = IDLE;
        end
      end

      SEARCH: begin
        steps_n = steps + STEP_1;
        if (bad_flags) begin
          state_n = DONE;
          found_n = 1'b0;
`ifdef SAR_SEARCH_FLAG_CHECK_EN
          err_n   = 1'b1;
`endif
        end else if (hit) begin
          state_n  = DONE;
          found_n  = 1'b1;
          result_n = guess;
        end else if (go_up) begin
          lo_n = {1'b0, guess} + BOUND_1;
          if (lo_n > hi) begin
            // Empty interval: the comparator contradicted earlier answers.
            state_n = DONE;
          end else begin
            guess_n = WIDTH'((lo_n + hi) >> 1);
          end
        end else if (go_down) begin
          hi_n = {1'b0, guess} - BOUND_1;
          // guess-1 < lo  <=>  guess <= lo; checked this way so a zero
          // guess cannot underflow hi into a huge value.
          if ({1'b0, guess} <= lo) begin
            state_n = DONE;
          end else begin
            guess_n = WIDTH'((lo + hi_n) >> 1);
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Search datapath registers; reset aborts any search in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo     <= '0;
      hi     <= '0;
      guess  <= '0;
      result <= '0;
      steps  <= '0;
      found  <= 1'b0;
    end else begin
      lo     <= lo_n;
      hi     <= hi_n;
      guess  <= guess_n;
      result <= result_n;
      steps  <= steps_n;
      found  <= found_n;
    end
  end

`ifdef SAR_SEARCH_FLAG_CHECK_EN
  // Sticky-until-next-start illegal-flag indicator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else begin
      err <= err_n;
    end
  end

  assign bus.error = err;
`else
  assign bus.error = 1'b0;
`endif

  // DONE never lasts more than one cycle, so done is simply the state decode.
  assign bus.guess  = guess;
  assign bus.busy   = (state == SEARCH);
  assign bus.done   = (state == DONE);
  assign bus.found  = found;
  assign bus.result = result;
  assign bus.steps  = steps;
  assign bus.state  = state;

endmodule
